// File: rtl/lcm_pkg.sv
// Shared types and constants for the lcm_8 datapath and its GCD step engine.
package lcm_pkg;

  localparam int LCM_W = 8;
  localparam int ITER  = 8;

  typedef enum logic [2:0] {
    IDLE,
    GCD,
    DIV,
    MUL,
    DONE
  } state_t;

endpackage

// File: rtl/lcm_8_gcd_iter.sv
// Subtractive Euclid engine: loads on start, one compare/subtract per cycle,
// done is combinational in the cycle x==y so the caller loses no edge.
module gcd_iter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] g
);

  logic [W-1:0] x, y;
  logic         busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      busy <= 1'b0;
    end else if (start) begin
      x    <= a;
      y    <= b;
      busy <= 1'b1;
    end else if (busy) begin
      if (x == y)     busy <= 1'b0;
      else if (x > y) x    <= x - y;
      else            y    <= y - x;
    end
  end

  assign done = busy && (x == y);
  assign g    = x;

endmodule

// File: rtl/lcm_8.sv
// Sequential LCM: subtractive GCD, 8-step restoring divide A/g, 8-step shift-add q*B.
// Optional macro LCM_GCD_OUT_EN exposes the GCD as gcd_out.
module lcm_8
  import lcm_pkg::*;
#(
  parameter int W = LCM_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out
`ifdef LCM_GCD_OUT_EN
  ,
  output logic [W-1:0]   gcd_out
`endif
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t state, state_nxt;

  logic [W-1:0]   ra, rb, g, q, rem, zero_g, gv;
  logic [2*W-1:0] mb;
  logic [CW-1:0]  cnt;
  logic           accept, zero_op, gstart, gdone;
  logic [W:0]     t;
  logic           t_ge;

  assign accept  = in_valid && in_ready;
  assign zero_op = (a == '0) || (b == '0);
  assign gstart  = accept && !zero_op;

`ifdef LCM_GCD_OUT_EN
  // gcd(0,x)=x; with one operand zero the OR is the other operand
  assign zero_g  = a | b;
  assign gcd_out = g;
`else
  assign zero_g  = '0;
`endif

  gcd_iter #(.W(W)) u_gcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (gstart),
    .a     (a),
    .b     (b),
    .done  (gdone),
    .g     (gv)
  );

  // restoring-divide trial: shift next dividend bit into the partial remainder
  assign t    = {rem, q[W-1]};
  assign t_ge = (t >= {1'b0, g});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)           state_nxt = zero_op ? DONE : GCD;
      GCD:  if (gdone)            state_nxt = DIV;
      DIV:  if (cnt == LAST)      state_nxt = MUL;
      MUL:  if (cnt == LAST)      state_nxt = DONE;
      DONE: if (out_ready)        state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra  <= '0;
      rb  <= '0;
      g   <= '0;
      q   <= '0;
      rem <= '0;
      mb  <= '0;
      cnt <= '0;
      out <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          ra <= a;
          rb <= b;
          if (zero_op) begin
            out <= '0;
            g   <= zero_g;
          end
        end
        GCD: if (gdone) begin
          g   <= gv;
          q   <= ra;
          rem <= '0;
          cnt <= '0;
        end
        DIV: begin
          q   <= {q[W-2:0], t_ge};
          rem <= t_ge ? (t[W-1:0] - g) : t[W-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            out <= '0;
            mb  <= {{W{1'b0}}, rb};
          end
        end
        MUL: begin
          out <= out + (q[0] ? mb : '0);
          q   <= q >> 1;
          mb  <= mb << 1;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_8.sv
// Self-checking bench for lcm_8: directed corner cases plus random pairs vs an arithmetic model.
module tb_lcm_8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out;
`ifdef LCM_GCD_OUT_EN
  logic [7:0]  gcd_out;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcm_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef LCM_GCD_OUT_EN
    ,
    .gcd_out   (gcd_out)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_gcd(input int x, input int y);
    int r;
    if (x == 0) return y;
    if (y == 0) return x;
    while (y != 0) begin
      r = x % y;
      x = y;
      y = r;
    end
    return x;
  endfunction

  function automatic int ref_lcm(input int x, input int y);
    if (x == 0 || y == 0) return 0;
    return (x / ref_gcd(x, y)) * y;
  endfunction

  // subtraction count equals the sum of Euclid quotients, minus the final exact step
  function automatic int ref_steps(input int x, input int y);
    int s, r, hi, lo;
    s = 0;
    hi = (x > y) ? x : y;
    lo = (x > y) ? y : x;
    while (lo != 0) begin
      s += hi / lo;
      r = hi % lo;
      hi = lo;
      lo = r;
    end
    return s - 1;
  endfunction

  task automatic run_op(input int ta, input int tb_, input int hold, input bit pulse);
    int cyc, exp_lat;
    logic [15:0] held;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    a = ta[7:0];
    b = tb_[7:0];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    exp_lat = (ta == 0 || tb_ == 0) ? 0 : ref_steps(ta, tb_) + 17;
    chk($sformatf("latency(%0d,%0d)", ta, tb_), cyc, exp_lat);
    chk($sformatf("out(%0d,%0d)", ta, tb_), out, ref_lcm(ta, tb_));
`ifdef LCM_GCD_OUT_EN
    chk($sformatf("gcd_out(%0d,%0d)", ta, tb_), gcd_out, ref_gcd(ta, tb_));
`endif
    held = out;
    for (int i = 0; i < hold; i++) begin
      in_valid = pulse ? 1'(i & 1) : 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
      if (pulse) begin
        chk("hold_out_stable", out, held);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int seen;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef LCM_GCD_OUT_EN
    chk("rst_gcd_out", gcd_out, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset mid-operation
    in_valid = 1'b1;
    a = 8'd255;
    b = 8'd254;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (49) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", out, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_stale", seen, 0);

    run_op(4, 6, 0, 0);
    run_op(12, 18, 0, 0);
    run_op(7, 7, 0, 0);
    run_op(1, 200, 0, 0);
    run_op(0, 9, 0, 0);
    run_op(0, 0, 0, 0);
    run_op(9, 0, 2, 1);
    run_op(255, 254, 20, 1);
    run_op(255, 255, 0, 0);

    for (int n = 0; n < 100; n++) begin
      int ra, rb;
      ra = (n % 17 == 5) ? 0 : int'($urandom_range(1, 255));
      rb = int'($urandom_range(0, 255));
      run_op(ra, rb, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
